io_responder: RTL and testbench



---
 rtl/io_resp_pkg.sv | 25 ++
 rtl/io_fifo.sv | 57 +++++
 rtl/io_responder.sv | 137 +++++++++++++
 tb/tb_io_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_resp_pkg.sv
// Shared constants for the IO responder: device address map, status bit layout and FIFO sizing.
package io_resp_pkg;

    localparam logic [7:0] ADDR_PORT0 = 8'h00;
    localparam logic [7:0] ADDR_PORT1 = 8'h01;
    localparam logic [7:0] ADDR_PORT2 = 8'h02;
    localparam logic [7:0] ADDR_PORT3 = 8'h03;
    localparam logic [7:0] ADDR_KBD_DEFAULT  = 8'h04;
    localparam logic [7:0] ADDR_STAT_DEFAULT = 8'h05;

    localparam int STAT_EMPTY = 7;
    localparam int STAT_FULL  = 6;

    localparam int FIFO_DEPTH_DEFAULT = 4;

    function automatic logic [7:0] status_byte(input logic empty, input logic full,
                                               input logic [4:0] count);
        logic [7:0] s;
        s = {3'b000, count};
        s[STAT_EMPTY] = empty;
        s[STAT_FULL]  = full;
        return s;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous power-of-two FIFO; push while full and pop while empty are ignored.
module io_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          in_clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wr_data,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage holds no state worth clearing; emptiness is tracked by count alone.
    always_ff @(posedge in_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_responder.sv
// Peripheral end of the CPU's 8-bit bidirectional IO channel: address latch,
// four output ports, a producer-fed input FIFO, and a qualified bus driver.
module io_responder
    import io_resp_pkg::*;
#(
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [7:0] ADDR_KBD   = ADDR_KBD_DEFAULT,
    parameter logic [7:0] ADDR_STAT  = ADDR_STAT_DEFAULT
) (
    input  logic       in_clk,
    input  logic       reset_n,
    inout  wire  [7:0] cpu_interface,
    input  logic       enable_input,
    input  logic       set_output,
    input  logic       data_address,
    output logic [7:0] port0,
    output logic [7:0] port1,
    output logic [7:0] port2,
    output logic [7:0] port3,
    output logic [3:0] out_strobe,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] sel_addr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          so_q;
    logic          ei_q;
    logic          so_rise;
    logic          ei_rise;
    logic          ei_fall;
    logic          rd_kbd;
    logic [7:0]    port_q [4];
    logic          port_hit;
    logic [1:0]    port_idx;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic          drive_en;
    logic          bus_oe;
    logic [7:0]    rd_data;

    assign so_rise  = set_output & ~so_q;
    assign ei_rise  = enable_input & ~ei_q;
    assign ei_fall  = ~enable_input & ei_q;
    assign port_hit = (sel_addr[7:2] == 6'd0);
    assign port_idx = sel_addr[1:0];

    assign port0 = port_q[0];
    assign port1 = port_q[1];
    assign port2 = port_q[2];
    assign port3 = port_q[3];

    // Edge history comes out of reset high so a strobe already asserted at release is not an edge.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            so_q <= 1'b1;
            ei_q <= 1'b1;
        end else begin
            so_q <= set_output;
            ei_q <= enable_input;
        end
    end

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_addr   <= 8'h00;
            out_strobe <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                port_q[i] <= 8'h00;
            end
        end else begin
            out_strobe <= 4'b0000;
            if (so_rise && data_address) begin
                sel_addr <= cpu_interface;
            end
            if (so_rise && !data_address && port_hit) begin
                port_q[port_idx]     <= cpu_interface;
                out_strobe[port_idx] <= 1'b1;
            end
        end
    end

    // Pop intent is decided at the start of the input cycle so the head stays put until it ends.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_kbd <= 1'b0;
        end else if (ei_rise) begin
            rd_kbd <= (sel_addr == ADDR_KBD) & ~data_address & ~fifo_empty;
        end else if (ei_fall) begin
            rd_kbd <= 1'b0;
        end
    end

    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign fifo_pop  = ei_fall & rd_kbd;

    io_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .in_clk  (in_clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Output cycles win over input cycles; reset releases the bus immediately.
    always_comb begin
        drive_en = reset_n & enable_input & ~data_address & ~set_output;
        bus_oe   = 1'b0;
        rd_data  = 8'h00;
        if (port_hit) begin
            bus_oe  = drive_en;
            rd_data = port_q[port_idx];
        end else if (sel_addr == ADDR_KBD) begin
            bus_oe  = drive_en;
            rd_data = fifo_empty ? 8'h00 : fifo_head;
        end else if (sel_addr == ADDR_STAT) begin
            bus_oe  = drive_en;
            rd_data = status_byte(fifo_empty, fifo_full, 5'(fifo_count));
        end
    end

    assign cpu_interface = bus_oe ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_io_responder.sv
// Directed and randomized bench for io_responder against a queue/array reference model.
module tb_io_responder;

    logic       in_clk = 1'b0;
    logic       reset_n;
    wire  [7:0] cpu_interface;
    logic       enable_input;
    logic       set_output;
    logic       data_address;
    logic [7:0] port0, port1, port2, port3;
    logic [3:0] out_strobe;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sel_addr;

    logic [7:0] cpu_drv;
    logic       cpu_oe;

    // An undriven bus reads as 8'hFF; any responder drive or contention shows up as a different value.
    pullup (cpu_interface);
    assign cpu_interface = cpu_oe ? cpu_drv : 8'bzzzz_zzzz;

    always #5 in_clk = ~in_clk;

    io_responder dut (
        .in_clk        (in_clk),
        .reset_n       (reset_n),
        .cpu_interface (cpu_interface),
        .enable_input  (enable_input),
        .set_output    (set_output),
        .data_address  (data_address),
        .port0         (port0),
        .port1         (port1),
        .port2         (port2),
        .port3         (port3),
        .out_strobe    (out_strobe),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sel_addr      (sel_addr)
    );

    logic [7:0] port_obs [4];
    assign port_obs[0] = port0;
    assign port_obs[1] = port1;
    assign port_obs[2] = port2;
    assign port_obs[3] = port3;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] ports_m [4];
    logic [7:0] fifo_m [$];
    logic [7:0] rd;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stat_m();
        int n;
        n = fifo_m.size();
        return {(n == 0), (n == 4), 1'b0, 5'(n)};
    endfunction

    task automatic check_ports(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_port%0d", tag, i), port_obs[i], ports_m[i]);
        end
    endtask

    // One CPU output cycle; returns at the negedge where the strobe cycle is visible.
    task automatic cpu_out(input logic da, input logic [7:0] v);
        @(negedge in_clk);
        data_address = da;
        cpu_drv      = v;
        cpu_oe       = 1'b1;
        set_output   = 1'b1;
        @(negedge in_clk);
        set_output   = 1'b0;
        cpu_oe       = 1'b0;
        data_address = 1'b0;
    endtask

    // One CPU input cycle; returns one negedge after the pop edge.
    task automatic cpu_in(output logic [7:0] v);
        @(negedge in_clk);
        data_address = 1'b0;
        enable_input = 1'b1;
        @(negedge in_clk);
        v            = cpu_interface;
        enable_input = 1'b0;
        @(negedge in_clk);
    endtask

    task automatic push_byte(input logic [7:0] v);
        int n;
        n = 0;
        @(negedge in_clk);
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 50) begin
            @(negedge in_clk);
            n++;
        end
        chk("push_ready", {7'd0, in_ready}, 8'h01);
        @(negedge in_clk);
        in_valid = 1'b0;
        if (in_ready || n < 50) fifo_m.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;

        for (int i = 0; i < 4; i++) ports_m[i] = 8'h00;
        reset_n      = 1'b0;
        enable_input = 1'b0;
        set_output   = 1'b1;
        data_address = 1'b0;
        cpu_drv      = 8'hEE;
        cpu_oe       = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;

        // Reset with set_output held high across release.
        repeat (3) @(negedge in_clk);
        reset_n = 1'b1;
        repeat (3) @(negedge in_clk);
        chk("rst_strobe", {4'd0, out_strobe}, 8'h00);
        set_output = 1'b0;
        cpu_oe     = 1'b0;
        @(negedge in_clk);
        check_ports("rst");
        chk("rst_sel", sel_addr, 8'h00);
        chk("rst_bus", cpu_interface, 8'hFF);
        chk("rst_ready", {7'd0, in_ready}, 8'h01);

        // Port write, then write to an unmapped address.
        cpu_out(1'b1, 8'h02);
        chk("sel02", sel_addr, 8'h02);
        cpu_out(1'b0, 8'hA5);
        ports_m[2] = 8'hA5;
        chk("wr_strobe", {4'd0, out_strobe}, 8'h04);
        check_ports("wr2");
        @(negedge in_clk);
        chk("wr_strobe_off", {4'd0, out_strobe}, 8'h00);
        cpu_out(1'b1, 8'h07);
        cpu_out(1'b0, 8'h3C);
        chk("wr7_strobe", {4'd0, out_strobe}, 8'h00);
        chk("sel07", sel_addr, 8'h07);
        check_ports("wr7");

        // FIFO basic reads, underflow and status.
        push_byte(8'h31);
        push_byte(8'h32);
        cpu_out(1'b1, 8'h04);
        cpu_in(rd); chk("kbd_rd1", rd, 8'h31); void'(fifo_m.pop_front());
        cpu_in(rd); chk("kbd_rd2", rd, 8'h32); void'(fifo_m.pop_front());
        cpu_in(rd); chk("kbd_empty", rd, 8'h00);
        cpu_out(1'b1, 8'h05);
        cpu_in(rd); chk("stat_empty", rd, 8'h80);

        // Fill, hold off the fifth byte, pop once, then drain across wrap.
        for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i));
        @(negedge in_clk);
        in_valid = 1'b1;
        in_data  = 8'h45;
        chk("full_ready", {7'd0, in_ready}, 8'h00);
        cpu_out(1'b1, 8'h05);
        cpu_in(rd); chk("stat_full", rd, 8'h44);
        chk("full_hold", {7'd0, in_ready}, 8'h00);
        cpu_out(1'b1, 8'h04);
        cpu_in(rd); chk("full_pop", rd, 8'h41); void'(fifo_m.pop_front());
        chk("ready_after_pop", {7'd0, in_ready}, 8'h01);
        @(negedge in_clk);
        in_valid = 1'b0;
        fifo_m.push_back(8'h45);
        for (int i = 0; i < 4; i++) begin
            exp = fifo_m.pop_front();
            cpu_in(rd); chk($sformatf("wrap_rd%0d", i), rd, exp);
        end

        // Simultaneous set_output and enable_input: CPU owns the bus.
        cpu_out(1'b1, 8'h00);
        cpu_out(1'b0, 8'h5A);
        ports_m[0] = 8'h5A;
        @(negedge in_clk);
        data_address = 1'b0;
        cpu_drv      = 8'h00;
        cpu_oe       = 1'b1;
        set_output   = 1'b1;
        enable_input = 1'b1;
        #1 chk("both_bus_a", cpu_interface, 8'h00);
        @(negedge in_clk);
        chk("both_bus_b", cpu_interface, 8'h00);
        set_output   = 1'b0;
        enable_input = 1'b0;
        cpu_oe       = 1'b0;
        ports_m[0]   = 8'h00;
        @(negedge in_clk);
        check_ports("both");
        @(negedge in_clk);
        data_address = 1'b1;
        enable_input = 1'b1;
        #1 chk("da1_bus", cpu_interface, 8'hFF);
        @(negedge in_clk);
        enable_input = 1'b0;
        data_address = 1'b0;

        // Randomized mix of writes, pushes, FIFO reads and readbacks.
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    a = 8'($urandom_range(0, 7));
                    d = 8'($urandom);
                    cpu_out(1'b1, a);
                    cpu_out(1'b0, d);
                    exp = (a < 4) ? (8'h01 << a) : 8'h00;
                    chk($sformatf("r%0d_strobe", it), {4'd0, out_strobe}, exp);
                    if (a < 4) ports_m[a[1:0]] = d;
                    check_ports($sformatf("r%0d", it));
                end
                1: begin
                    if (fifo_m.size() < 4) push_byte(8'($urandom));
                end
                2: begin
                    cpu_out(1'b1, 8'h04);
                    exp = (fifo_m.size() > 0) ? fifo_m.pop_front() : 8'h00;
                    cpu_in(rd);
                    chk($sformatf("r%0d_kbd", it), rd, exp);
                end
                default: begin
                    a = 8'($urandom_range(0, 6));
                    cpu_out(1'b1, a);
                    if (a < 4)       exp = ports_m[a[1:0]];
                    else if (a == 5) exp = stat_m();
                    else if (a == 4) exp = (fifo_m.size() > 0) ? fifo_m[0] : 8'h00;
                    else             exp = 8'hFF;
                    cpu_in(rd);
                    if (a == 4 && fifo_m.size() > 0) void'(fifo_m.pop_front());
                    chk($sformatf("r%0d_rb%0h", it, a), rd, exp);
                end
            endcase
        end

        // Reset in the middle of a KBD input cycle.
        push_byte(8'h77);
        cpu_out(1'b1, 8'h04);
        exp = fifo_m[0];
        @(negedge in_clk);
        data_address = 1'b0;
        enable_input = 1'b1;
        @(negedge in_clk);
        chk("mid_bus", cpu_interface, exp);
        #2 reset_n = 1'b0;
        #1 chk("mid_rst_bus", cpu_interface, 8'hFF);
        chk("mid_rst_ready", {7'd0, in_ready}, 8'h01);
        @(negedge in_clk);
        reset_n = 1'b1;
        fifo_m.delete();
        for (int i = 0; i < 4; i++) ports_m[i] = 8'h00;
        check_ports("mid_rst");
        push_byte(8'h66);
        @(negedge in_clk);
        enable_input = 1'b0;
        repeat (2) @(negedge in_clk);
        cpu_out(1'b1, 8'h05);
        cpu_in(rd); chk("mid_stat", rd, 8'h01);
        cpu_out(1'b1, 8'h04);
        cpu_in(rd); chk("mid_kbd", rd, 8'h66);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
